// File: rtl/sega_pad_reader_pkg.sv
// Shared constants for the DB9 pad reader: poll step codes, button/pin bit
// positions and the 12-bit active-low button word type.
package joy_pkg;
    localparam int STEP_W = 8;

    localparam logic [7:0] S0 = 8'd0;
    localparam logic [7:0] S1 = 8'd1;
    localparam logic [7:0] S2 = 8'd2;
    localparam logic [7:0] S3 = 8'd3;
    localparam logic [7:0] S4 = 8'd4;
    localparam logic [7:0] S5 = 8'd5;
    localparam logic [7:0] S6 = 8'd6;
    localparam logic [7:0] S7 = 8'd7;

    // button word layout {M,X,Y,Z,S,A,C,B,R,L,D,U}
    localparam int J_U = 0;
    localparam int J_D = 1;
    localparam int J_L = 2;
    localparam int J_R = 3;
    localparam int J_B = 4;
    localparam int J_C = 5;
    localparam int J_A = 6;
    localparam int J_S = 7;
    localparam int J_Z = 8;
    localparam int J_Y = 9;
    localparam int J_X = 10;
    localparam int J_M = 11;

    // raw pin layout {p9,p6,right,left,down,up}
    localparam int P_U  = 0;
    localparam int P_D  = 1;
    localparam int P_L  = 2;
    localparam int P_R  = 3;
    localparam int P_P6 = 4;
    localparam int P_P9 = 5;

    typedef logic [11:0] joy_word_t;

    localparam joy_word_t   JOY_RELEASED = 12'hFFF;
    localparam logic [5:0]  PINS_IDLE    = 6'h3F;
endpackage

// File: rtl/sega_pad_reader_if.sv
// Pad-side and core-side signals of the pad reader. master is the reader,
// slave is the pads plus whatever consumes the decoded words.
interface sega_pad_reader_if;
    import joy_pkg::*;

    logic [5:0] joy1_pins_i;
    logic [5:0] joy2_pins_i;
    logic       joyX_p7_o;
    joy_word_t  joy1_o;
    joy_word_t  joy2_o;
    logic       six1_o;
    logic       six2_o;
    logic       poll_done_o;

    modport master (
        input  joy1_pins_i, joy2_pins_i,
        output joyX_p7_o, joy1_o, joy2_o, six1_o, six2_o, poll_done_o
    );

    modport slave (
        output joy1_pins_i, joy2_pins_i,
        input  joyX_p7_o, joy1_o, joy2_o, six1_o, six2_o, poll_done_o
    );
endinterface

// File: rtl/sega_pad_reader_decode.sv
// Per-port decoder: synchronises the raw pins, assembles the button word in a
// shadow register across steps S2..S6 and commits it atomically at S7.
module sega_pad_decode
    import joy_pkg::*;
(
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [5:0]        pins,
    input  logic [STEP_W-1:0] step,
    input  logic              tick,
    output joy_word_t         joy,
    output logic              six
);
    logic [5:0] pins_meta;
    logic [5:0] pins_sync;
    joy_word_t  shadow;
    logic       sixflag;
    logic       md_pad;
    logic       rldu_low;

    // Mega Drive pads pull R and L low while select is low; SMS pads never do.
    assign md_pad   = ~pins_sync[P_R] & ~pins_sync[P_L];
    assign rldu_low = (pins_sync[3:0] == 4'h0);

    // two-flop synchroniser for the asynchronous pad pins
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pins_meta <= PINS_IDLE;
            pins_sync <= PINS_IDLE;
        end else begin
            pins_meta <= pins;
            pins_sync <= pins_meta;
        end
    end

    // step-driven capture into the shadow word, committed to the outputs at S7
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            shadow  <= JOY_RELEASED;
            sixflag <= 1'b0;
            joy     <= JOY_RELEASED;
            six     <= 1'b0;
        end else if (tick) begin
            case (step)
                S2: begin
                    shadow[J_C:J_U] <= pins_sync;
                    sixflag         <= 1'b0;
                end
                S3: begin
                    if (md_pad)
                        shadow[J_S:J_A] <= pins_sync[P_P9:P_P6];
                    else
                        shadow[J_S:J_B] <= {2'b11, pins_sync[P_P9:P_P6]};
                end
                S5: begin
                    if (rldu_low)
                        sixflag <= 1'b1;
                end
                S6: begin
                    shadow[J_M:J_Z] <= sixflag ? pins_sync[P_R:P_U] : 4'hF;
                end
                S7: begin
                    joy <= shadow;
                    six <= sixflag;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/sega_pad_reader.sv
// Self-timed DB9 pad poller: divider, poll step counter, shared select line
// and the commit pulse; one decoder per port.
module sega_pad_reader
    import joy_pkg::*;
#(
    parameter int TICK_DIV   = 1536,
    parameter int IDLE_STEPS = 248
)
(
    input  logic              clk_sys,
    input  logic              reset,
    sega_pad_reader_if.master bus
);
    localparam int                DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(7 + IDLE_STEPS);

    logic [DIV_W-1:0]  div;
    logic [STEP_W-1:0] step;
    logic              tick;
    logic              p7;
    logic              poll_done;

    assign tick = (div == DIV_LAST);

    // poll step timebase
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            div <= '0;
        else if (tick)
            div <= '0;
        else
            div <= div + 1'b1;
    end

    // step counter: 8 active steps followed by the idle steps
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            step <= '0;
        else if (tick)
            step <= (step == STEP_LAST) ? '0 : step + 1'b1;
    end

    // select line: low after leaving S0/S2/S4/S6, high otherwise
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            p7 <= 1'b1;
        end else if (tick) begin
            case (step)
                S0, S2, S4, S6: p7 <= 1'b0;
                default:        p7 <= 1'b1;
            endcase
        end
    end

    // one-cycle strobe coinciding with the output commit
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            poll_done <= 1'b0;
        else
            poll_done <= tick && (step == S7);
    end

    assign bus.joyX_p7_o   = p7;
    assign bus.poll_done_o = poll_done;

    sega_pad_decode u_dec1 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .pins    (bus.joy1_pins_i),
        .step    (step),
        .tick    (tick),
        .joy     (bus.joy1_o),
        .six     (bus.six1_o)
    );

    sega_pad_decode u_dec2 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .pins    (bus.joy2_pins_i),
        .step    (step),
        .tick    (tick),
        .joy     (bus.joy2_o),
        .six     (bus.six2_o)
    );
endmodule

// File: tb/tb_sega_pad_reader.sv
// Bench for sega_pad_reader: behavioural pads driven by select/phase, expected
// words queued when the pads are set up and checked at each poll commit.
module tb_sega_pad_reader;
    import joy_pkg::*;

    localparam int TICK_DIV   = 4;
    localparam int IDLE_STEPS = 8;
    localparam int POLL_CYC   = (8 + IDLE_STEPS) * TICK_DIV;
    localparam int COMMIT_CYC = 8 * TICK_DIV;

    typedef enum int {PAD_NONE, PAD_SMS, PAD_MD3, PAD_MD6} pad_t;
    typedef struct {
        joy_word_t w1;
        joy_word_t w2;
        logic      s1;
        logic      s2;
    } exp_t;

    logic      clk_sys = 1'b0;
    logic      reset   = 1'b1;
    pad_t      pad1    = PAD_NONE;
    pad_t      pad2    = PAD_NONE;
    joy_word_t held1   = 12'hFFF;
    joy_word_t held2   = 12'hFFF;
    int        phase   = 0;
    int        p7_falls = 0;
    exp_t      sb[$];
    exp_t      e;
    int        n_checks = 0;
    int        n_fail   = 0;

    always #5 clk_sys = ~clk_sys;

    sega_pad_reader_if bus();

    sega_pad_reader #(.TICK_DIV(TICK_DIV), .IDLE_STEPS(IDLE_STEPS)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    // pad behaviour: what each pad type presents on its pins
    function automatic logic [5:0] pad_pins(pad_t t, joy_word_t h, logic sel, int ph);
        logic [5:0] r;
        r = 6'h3F;
        case (t)
            PAD_SMS: r = h[5:0];
            PAD_MD3, PAD_MD6: begin
                if (sel)
                    r = (t == PAD_MD6 && ph == 3) ? {h[J_C], h[J_B], h[J_M], h[J_X], h[J_Y], h[J_Z]} : h[5:0];
                else
                    r = (t == PAD_MD6 && ph == 3) ? {h[J_S], h[J_A], 4'b0000}
                                                  : {h[J_S], h[J_A], 2'b00, h[J_D], h[J_U]};
            end
            default: r = 6'h3F;
        endcase
        return r;
    endfunction

    // what the core should see for a pad with the given buttons held
    function automatic joy_word_t exp_word(pad_t t, joy_word_t h);
        case (t)
            PAD_SMS: return {4'hF, 2'b11, h[5:0]};
            PAD_MD3: return {4'hF, h[7:0]};
            PAD_MD6: return h;
            default: return 12'hFFF;
        endcase
    endfunction

    assign bus.joy1_pins_i = pad_pins(pad1, held1, bus.joyX_p7_o, phase);
    assign bus.joy2_pins_i = pad_pins(pad2, held2, bus.joyX_p7_o, phase);

    // select-low count within the current poll, as a real 6-button pad tracks it
    always @(negedge bus.joyX_p7_o or posedge reset) begin
        if (reset) begin
            phase <= 0;
        end else begin
            phase    <= (phase >= 4) ? 1 : phase + 1;
            p7_falls <= p7_falls + 1;
        end
    end

    task automatic push_exp();
        exp_t x;
        x.w1 = exp_word(pad1, held1);
        x.w2 = exp_word(pad2, held2);
        x.s1 = (pad1 == PAD_MD6);
        x.s2 = (pad2 == PAD_MD6);
        sb.push_back(x);
    endtask

    // bounded wait for the next commit pulse; an expired bound counts as a failure
    task automatic wait_poll(input string name, output int cyc);
        bit seen;
        seen = 0;
        cyc  = 0;
        for (int c = 0; c < 3 * POLL_CYC; c++) begin
            @(negedge clk_sys);
            cyc++;
            if (bus.poll_done_o) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no poll_done within %0d cycles", name, 3 * POLL_CYC);
        end
    endtask

    // bounded wait for a given select phase (phase count plus select level)
    task automatic wait_phase(input int ph, input logic sel, input string name);
        bit seen;
        seen = 0;
        for (int c = 0; c < 3 * POLL_CYC; c++) begin
            @(negedge clk_sys);
            if (phase == ph && bus.joyX_p7_o == sel) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout waiting for phase %0d sel %b", name, ph, sel);
        end
    endtask

    task automatic test_reset();
        int cyc;
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        n_checks++;
        if (bus.joyX_p7_o !== 1'b1 || bus.poll_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: p7=%b poll_done=%b expected p7=1 poll_done=0", bus.joyX_p7_o, bus.poll_done_o);
        end
        n_checks++;
        if (bus.joy1_o !== 12'hFFF || bus.joy2_o !== 12'hFFF || bus.six1_o !== 1'b0 || bus.six2_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: joy1=%h joy2=%h six=%b%b expected FFF FFF 00", bus.joy1_o, bus.joy2_o, bus.six1_o, bus.six2_o);
        end
        push_exp();
        reset = 1'b0;
        wait_poll("reset_first", cyc);
        n_checks++;
        if (cyc !== COMMIT_CYC) begin
            n_fail++;
            $display("FAIL reset_first_latency: got %0d cycles expected %0d", cyc, COMMIT_CYC);
        end
        e = sb.pop_front();
        n_checks++;
        if (bus.joy1_o !== e.w1 || bus.joy2_o !== e.w2 || bus.six1_o !== e.s1 || bus.six2_o !== e.s2) begin
            n_fail++;
            $display("FAIL reset_first_poll: joy1=%h joy2=%h six=%b%b expected %h %h %b%b",
                     bus.joy1_o, bus.joy2_o, bus.six1_o, bus.six2_o, e.w1, e.w2, e.s1, e.s2);
        end
    endtask

    task automatic test_idle();
        int cyc;
        int f0;
        pad1 = PAD_NONE; pad2 = PAD_NONE; held1 = 12'hFFF; held2 = 12'hFFF;
        repeat (3) push_exp();
        f0 = p7_falls;
        for (int i = 0; i < 3; i++) begin
            wait_poll("idle", cyc);
            e = sb.pop_front();
            n_checks++;
            if (bus.joy1_o !== e.w1 || bus.joy2_o !== e.w2 || bus.six1_o !== e.s1 || bus.six2_o !== e.s2) begin
                n_fail++;
                $display("FAIL idle_poll%0d: joy1=%h joy2=%h six=%b%b expected %h %h %b%b",
                         i, bus.joy1_o, bus.joy2_o, bus.six1_o, bus.six2_o, e.w1, e.w2, e.s1, e.s2);
            end
            n_checks++;
            if (p7_falls - f0 !== 4) begin
                n_fail++;
                $display("FAIL idle_p7_pulses%0d: got %0d select pulses expected 4", i, p7_falls - f0);
            end
            f0 = p7_falls;
        end
    endtask

    // runs n clean polls with the given pads and checks every commit
    task automatic test_pads(input string name, input pad_t t1, input joy_word_t h1,
                             input pad_t t2, input joy_word_t h2, input int n);
        int cyc;
        pad1 = t1; held1 = h1; pad2 = t2; held2 = h2;
        repeat (n) push_exp();
        for (int i = 0; i < n; i++) begin
            wait_poll(name, cyc);
            e = sb.pop_front();
            n_checks++;
            if (bus.joy1_o !== e.w1 || bus.joy2_o !== e.w2 || bus.six1_o !== e.s1 || bus.six2_o !== e.s2) begin
                n_fail++;
                $display("FAIL %s_poll%0d: joy1=%h joy2=%h six=%b%b expected %h %h %b%b",
                         name, i, bus.joy1_o, bus.joy2_o, bus.six1_o, bus.six2_o, e.w1, e.w2, e.s1, e.s2);
            end
        end
    endtask

    task automatic test_md3();
        test_pads("md3", PAD_MD3, 12'hFFF & ~(12'h1 << J_A) & ~(12'h1 << J_U), PAD_NONE, 12'hFFF, 2);
        n_checks++;
        if (bus.joy1_o !== 12'hFBE || bus.six1_o !== 1'b0 || bus.joy2_o !== 12'hFFF) begin
            n_fail++;
            $display("FAIL md3_word: joy1=%h six1=%b joy2=%h expected FBE 0 FFF", bus.joy1_o, bus.six1_o, bus.joy2_o);
        end
    endtask

    task automatic test_md6();
        test_pads("md6", PAD_MD6, 12'hFFF & ~(12'h1 << J_X) & ~(12'h1 << J_S),
                  PAD_SMS, 12'hFFF & ~(12'h1 << J_B), 2);
        n_checks++;
        if (bus.joy1_o[11:8] !== 4'hB || bus.joy1_o[7] !== 1'b0 || bus.six1_o !== 1'b1) begin
            n_fail++;
            $display("FAIL md6_word: joy1=%h six1=%b expected [11:8]=B bit7=0 six1=1", bus.joy1_o, bus.six1_o);
        end
        n_checks++;
        if (bus.joy2_o !== 12'hFEF || bus.six2_o !== 1'b0) begin
            n_fail++;
            $display("FAIL md6_port2: joy2=%h six2=%b expected FEF 0", bus.joy2_o, bus.six2_o);
        end
    endtask

    task automatic test_sms();
        test_pads("sms", PAD_SMS, 12'hFFF & ~(12'h1 << J_C), PAD_MD3, 12'hFFF, 2);
        n_checks++;
        if (bus.joy1_o !== 12'hFDF || bus.joy1_o[7:6] !== 2'b11 || bus.six1_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sms_word: joy1=%h six1=%b expected FDF 0", bus.joy1_o, bus.six1_o);
        end
    endtask

    task automatic test_mid_poll_change();
        int  cyc;
        bit  held_ok;
        test_pads("chg_pre", PAD_MD3, 12'hFBE, PAD_NONE, 12'hFFF, 1);
        push_exp();
        wait_phase(2, 1'b1, "chg_s4");
        held1 = 12'hFED;
        push_exp();
        held_ok = 1;
        for (int c = 0; c < 3 * POLL_CYC; c++) begin
            if (bus.poll_done_o) break;
            if (bus.joy1_o !== 12'hFBE) held_ok = 0;
            @(negedge clk_sys);
        end
        n_checks++;
        if (!held_ok) begin
            n_fail++;
            $display("FAIL chg_hold: joy1 changed before commit, now %h expected FBE until S7", bus.joy1_o);
        end
        for (int i = 0; i < 2; i++) begin
            if (i == 1) wait_poll("chg", cyc);
            e = sb.pop_front();
            n_checks++;
            if (bus.joy1_o !== e.w1 || bus.joy2_o !== e.w2 || bus.six1_o !== e.s1 || bus.six2_o !== e.s2) begin
                n_fail++;
                $display("FAIL chg_poll%0d: joy1=%h joy2=%h six=%b%b expected %h %h %b%b",
                         i, bus.joy1_o, bus.joy2_o, bus.six1_o, bus.six2_o, e.w1, e.w2, e.s1, e.s2);
            end
            if (i == 0) begin
                @(negedge clk_sys);
                n_checks++;
                if (bus.poll_done_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL chg_pulse_width: poll_done=%b one cycle later expected 0", bus.poll_done_o);
                end
            end
        end
    endtask

    task automatic test_reset_mid_poll();
        int cyc;
        pad1 = PAD_MD3; held1 = 12'hFBE;
        wait_poll("rst_pre", cyc);
        wait_phase(2, 1'b0, "rst_s3");
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.joyX_p7_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_s3_p7: p7=%b expected 1", bus.joyX_p7_o);
        end
        @(negedge clk_sys);
        reset = 1'b0;
        wait_poll("rst_pre2", cyc);
        wait_phase(2, 1'b1, "rst_s4");
        n_checks++;
        if (bus.joy1_o !== 12'hFBE) begin
            n_fail++;
            $display("FAIL rst_pre_word: joy1=%h expected FBE", bus.joy1_o);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.joyX_p7_o !== 1'b1 || bus.joy1_o !== 12'hFFF || bus.joy2_o !== 12'hFFF || bus.six1_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_s4: p7=%b joy1=%h joy2=%h six1=%b expected 1 FFF FFF 0",
                     bus.joyX_p7_o, bus.joy1_o, bus.joy2_o, bus.six1_o);
        end
        sb.delete();
        repeat (2) @(negedge clk_sys);
        push_exp();
        reset = 1'b0;
        wait_poll("rst_after", cyc);
        n_checks++;
        if (cyc !== COMMIT_CYC) begin
            n_fail++;
            $display("FAIL rst_after_latency: got %0d cycles expected %0d", cyc, COMMIT_CYC);
        end
        e = sb.pop_front();
        n_checks++;
        if (bus.joy1_o !== e.w1 || bus.joy2_o !== e.w2 || bus.six1_o !== e.s1 || bus.six2_o !== e.s2) begin
            n_fail++;
            $display("FAIL rst_after_poll: joy1=%h joy2=%h six=%b%b expected %h %h %b%b",
                     bus.joy1_o, bus.joy2_o, bus.six1_o, bus.six2_o, e.w1, e.w2, e.s1, e.s2);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_md3();
        test_md6();
        test_sms();
        test_mid_poll_change();
        test_reset_mid_poll();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
